// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard unit: per-register ready countdown, MDU occupancy,
// WAW protection, flush cleanup and an EX/MEM/WB tag pipe for forwarding selects.
module hazard_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int MDU_LAT  = 4,
   parameter int CNT_W    = 4,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_has_rs1,
   input  logic              id_has_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_has_rd,
   input  logic [1:0]        id_class,
   input  logic              flush,
   output logic              stall_id,
   output logic              bubble_exe,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              mdu_busy,
   output logic [PERF_W-1:0] stall_count
);

   localparam int NREG = 1 << REG_AW;

   localparam logic [1:0] CLS_ALU  = 2'b00;
   localparam logic [1:0] CLS_LOAD = 2'b01;
   localparam logic [1:0] CLS_MDU  = 2'b10;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   localparam logic [CNT_W-1:0] LOAD_SET = CNT_W'(LOAD_LAT);
   localparam logic [CNT_W-1:0] MDU_SET  = CNT_W'(MDU_LAT);

   function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
      return (c == '0) ? c : c - CNT_W'(1);
   endfunction

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + PERF_W'(1);
   endfunction

   function automatic logic [1:0] fwd_pick(
      input logic              has,
      input logic [REG_AW-1:0] rs,
      input logic              e0,
      input logic [REG_AW-1:0] r0,
      input logic              e1,
      input logic [REG_AW-1:0] r1,
      input logic              e2,
      input logic [REG_AW-1:0] r2
   );
      if (!has || rs == '0) return FWD_RF;
      if (e0 && r0 == rs)   return FWD_EX;
      if (e1 && r1 == rs)   return FWD_MEM;
      if (e2 && r2 == rs)   return FWD_WB;
      return FWD_RF;
   endfunction

   logic [CNT_W-1:0]  cnt [NREG];
   logic [CNT_W-1:0]  mdu_cnt;

   logic              vld_p0, vld_p1, vld_p2;
   logic [REG_AW-1:0] rd_p0, rd_p1, rd_p2;
   logic              has_rd_p0, has_rd_p1, has_rd_p2;
   logic [1:0]        cls_p0, cls_p1, cls_p2;

   logic              haz_rs1, haz_rs2, haz_rd, haz_mdu, hazard, issue;
   logic              elig_p0, elig_p1, elig_p2;
   logic              set_rd, kill_p0_cnt, kill_p0_mdu;

   // ID stage: hazard detection against the scoreboard
   always_comb begin
      haz_rs1 = id_has_rs1 && (id_rs1 != '0) && (cnt[id_rs1] != '0);
      haz_rs2 = id_has_rs2 && (id_rs2 != '0) && (cnt[id_rs2] != '0);
      haz_rd  = id_has_rd  && (id_rd  != '0) && (cnt[id_rd]  != '0);
      haz_mdu = (id_class == CLS_MDU) && (mdu_cnt != '0);
      hazard  = id_valid && (haz_rs1 || haz_rs2 || haz_rd || haz_mdu);
   end

   assign stall_id   = hazard & ~flush;
   assign bubble_exe = stall_id;
   assign issue      = id_valid & ~stall_id & ~flush;
   assign mdu_busy   = (mdu_cnt != '0);

   assign set_rd      = issue && id_has_rd && (id_rd != '0);
   assign kill_p0_cnt = flush && vld_p0 && has_rd_p0 &&
                        ((cls_p0 == CLS_LOAD) || (cls_p0 == CLS_MDU));
   assign kill_p0_mdu = flush && vld_p0 && (cls_p0 == CLS_MDU);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
         mdu_cnt <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) cnt[i] <= cnt_dec(cnt[i]);
         if (set_rd && id_class == CLS_LOAD) cnt[id_rd] <= LOAD_SET;
         if (set_rd && id_class == CLS_MDU)  cnt[id_rd] <= MDU_SET;
         // A killed long-latency op in EX must not leave its destination pending.
         if (kill_p0_cnt) cnt[rd_p0] <= '0;

         mdu_cnt <= cnt_dec(mdu_cnt);
         if (issue && id_class == CLS_MDU) mdu_cnt <= MDU_SET;
         if (kill_p0_mdu) mdu_cnt <= '0;
      end
   end

   // EX (p0) / MEM (p1) / WB (p2) tag pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p0 <= issue;
         vld_p1 <= vld_p0 & ~flush;
         vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge clk) begin
      rd_p0     <= id_rd;
      has_rd_p0 <= id_has_rd;
      cls_p0    <= id_class;
      rd_p1     <= rd_p0;
      has_rd_p1 <= has_rd_p0;
      cls_p1    <= cls_p0;
      rd_p2     <= rd_p1;
      has_rd_p2 <= has_rd_p1;
      cls_p2    <= cls_p1;
   end

   // Forwarding selects: a LOAD is only forwardable once it reaches MEM
   always_comb begin
      elig_p0 = vld_p0 && has_rd_p0 && (rd_p0 != '0) && (cls_p0 == CLS_ALU);
      elig_p1 = vld_p1 && has_rd_p1 && (rd_p1 != '0) &&
                ((cls_p1 == CLS_ALU) || (cls_p1 == CLS_LOAD));
      elig_p2 = vld_p2 && has_rd_p2 && (rd_p2 != '0) &&
                ((cls_p2 == CLS_ALU) || (cls_p2 == CLS_LOAD));
      fwd_a_sel = fwd_pick(id_has_rs1, id_rs1, elig_p0, rd_p0, elig_p1, rd_p1, elig_p2, rd_p2);
      fwd_b_sel = fwd_pick(id_has_rs2, id_rs2, elig_p0, rd_p0, elig_p1, rd_p1, elig_p2, rd_p2);
   end

   always_ff @(posedge clk) begin
      if (rst)           stall_count <= '0;
      else if (stall_id) stall_count <= sat_inc(stall_count);
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard: per-cycle inputs with hand-computed
// expected stall/forward/busy/counter values, plus a reset-mid-operation sequence.
module tb_hazard_scoreboard;

   localparam int AW = 5;
   localparam int PW = 3;
   localparam int NV = 31;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [AW-1:0] id_rs1, id_rs2, id_rd;
   logic          id_has_rs1, id_has_rs2, id_has_rd;
   logic [1:0]    id_class;
   logic          flush;
   logic          stall_id, bubble_exe, mdu_busy;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic [PW-1:0] stall_count;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .REG_AW(AW), .LOAD_LAT(1), .MDU_LAT(4), .CNT_W(4), .PERF_W(PW)
   ) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_has_rs1(id_has_rs1), .id_has_rs2(id_has_rs2),
      .id_rd(id_rd), .id_has_rd(id_has_rd), .id_class(id_class),
      .flush(flush), .stall_id(stall_id), .bubble_exe(bubble_exe),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .mdu_busy(mdu_busy), .stall_count(stall_count)
   );

   typedef struct {
      logic          v;
      logic [AW-1:0] a;
      logic          ha;
      logic [AW-1:0] b;
      logic          hb;
      logic [AW-1:0] d;
      logic          hd;
      logic [1:0]    c;
      logic          f;
      logic          st;
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic          mb;
      logic [PW-1:0] sc;
   } vec_t;

   vec_t vecs [NV];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input int v, input int a, input int ha, input int b,
                               input int hb, input int d, input int hd, input int c,
                               input int f, input int st, input int fa, input int fb,
                               input int mb, input int sc);
      vec_t r;
      r.v  = v[0];      r.a  = AW'(a);    r.ha = ha[0];
      r.b  = AW'(b);    r.hb = hb[0];     r.d  = AW'(d);
      r.hd = hd[0];     r.c  = 2'(c);     r.f  = f[0];
      r.st = st[0];     r.fa = 2'(fa);    r.fb = 2'(fb);
      r.mb = mb[0];     r.sc = PW'(sc);
      return r;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h expected=%0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      id_valid   = x.v;
      id_rs1     = x.a;  id_has_rs1 = x.ha;
      id_rs2     = x.b;  id_has_rs2 = x.hb;
      id_rd      = x.d;  id_has_rd  = x.hd;
      id_class   = x.c;
      flush      = x.f;
   endtask

   task automatic check_outs(input int idx, input vec_t x);
      chk("stall_id",    idx, 32'(stall_id),    32'(x.st));
      chk("bubble_exe",  idx, 32'(bubble_exe),  32'(x.st));
      chk("fwd_a_sel",   idx, 32'(fwd_a_sel),   32'(x.fa));
      chk("fwd_b_sel",   idx, 32'(fwd_b_sel),   32'(x.fb));
      chk("mdu_busy",    idx, 32'(mdu_busy),    32'(x.mb));
      chk("stall_count", idx, 32'(stall_count), 32'(x.sc));
   endtask

   initial begin
      //               v  a ha  b hb  d hd c  f   st fa fb mb sc
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // reset state
      vecs[1]  = mk(1, 0, 0, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0, 0); // LOAD x5
      vecs[2]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0,  1, 0, 0, 0, 0); // load-use stall
      vecs[3]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0,  0, 2, 0, 0, 1); // fwd from MEM
      vecs[4]  = mk(1, 1, 1, 2, 1, 3, 1, 0, 0,  0, 0, 0, 0, 1); // ADD x3
      vecs[5]  = mk(1, 6, 1, 3, 1, 8, 1, 0, 0,  0, 2, 1, 0, 1); // x3 from EX, x6 from MEM
      vecs[6]  = mk(1, 3, 1, 8, 1,10, 1, 0, 0,  0, 2, 1, 0, 1);
      vecs[7]  = mk(1, 0, 1, 3, 1,11, 1, 0, 0,  0, 0, 3, 0, 1); // x3 from WB
      vecs[8]  = mk(1,11, 1, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 1); // write to x0
      vecs[9]  = mk(1, 0, 1,11, 1,12, 1, 0, 0,  0, 0, 2, 0, 1); // x0 never forwarded
      vecs[10] = mk(1,12, 0,12, 1,13, 0, 3, 0,  0, 0, 1, 0, 1); // has_rs1=0 gates
      vecs[11] = mk(1,12, 1, 0, 0, 7, 1, 2, 0,  0, 2, 0, 0, 1); // MUL x7
      vecs[12] = mk(1, 7, 1, 0, 0,14, 1, 0, 0,  1, 0, 0, 1, 1);
      vecs[13] = mk(1, 1, 1, 0, 0,15, 1, 2, 0,  1, 0, 0, 1, 2); // 2nd MDU blocked
      vecs[14] = mk(1, 7, 1, 0, 0,14, 1, 0, 0,  1, 0, 0, 1, 3);
      vecs[15] = mk(1, 7, 1, 0, 0,14, 1, 0, 0,  1, 0, 0, 1, 4);
      vecs[16] = mk(1, 7, 1, 0, 0,14, 1, 0, 0,  0, 0, 0, 0, 5); // issues, MDU reads RF
      vecs[17] = mk(1, 0, 0, 0, 0, 9, 1, 2, 0,  0, 0, 0, 0, 5); // MDU x9
      vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 5);
      vecs[19] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  1, 0, 0, 1, 5); // WAW stall
      vecs[20] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  1, 0, 0, 1, 6);
      vecs[21] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  1, 0, 0, 1, 7); // counter saturates next
      vecs[22] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0, 7);
      vecs[23] = mk(1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 0, 7); // LOAD x4
      vecs[24] = mk(1, 4, 1, 0, 0,16, 1, 0, 1,  0, 0, 0, 0, 7); // flush masks stall
      vecs[25] = mk(1, 4, 1, 0, 0,16, 1, 0, 0,  0, 0, 0, 0, 7); // MEM tag killed
      vecs[26] = mk(1, 0, 0, 0, 0,20, 1, 2, 0,  0, 0, 0, 0, 7); // MDU x20
      vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 7); // flush MDU in EX
      vecs[28] = mk(1,20, 1,16, 1,17, 1, 0, 0,  0, 0, 3, 0, 7); // x20 cleared
      vecs[29] = mk(1,17, 1, 0, 0,18, 1, 1, 1,  0, 1, 0, 0, 7); // LOAD with flush
      vecs[30] = mk(1,18, 1, 0, 0,19, 1, 0, 0,  0, 0, 0, 0, 7); // no pending x18

      rst = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         #2;
         check_outs(i, vecs[i]);
         @(negedge clk);
      end

      // Reset in the middle of a pending MDU op
      drive(mk(1, 0, 0, 0, 0, 21, 1, 2, 0, 0, 0, 0, 0, 0));
      #2;
      chk("rst_seq_mdu_issue", 100, 32'(stall_id), 32'(0));
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      chk("rst_seq_busy_before", 101, 32'(mdu_busy), 32'(1));
      chk("rst_seq_count_before", 101, 32'(stall_count), 32'(7));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(mk(1, 21, 1, 19, 1, 22, 1, 0, 0, 0, 0, 0, 0, 0));
      #2;
      check_outs(102, mk(1, 21, 1, 19, 1, 22, 1, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      drive(mk(1, 22, 1, 0, 0, 23, 1, 0, 0, 0, 1, 0, 0, 0));
      #2;
      check_outs(103, mk(1, 22, 1, 0, 0, 23, 1, 0, 0, 0, 1, 0, 0, 0));
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
